// File: rtl/dual_port_mem_arbiter_if.sv
// Bus bundle between two processor-style requesters, the shared 64x8
// memory and the arbiter.
//   slave  : arbiter view (takes requests and mem_rdata, drives ack/rdata/mem_*)
//   master : environment view (requesters plus memory)
// Signals per requester N: reqN, rwbN (1 = read), addrN[5:0], wdataN[7:0],
// ackN (one-cycle pulse), rdataN[7:0]. Memory side: mem_cs, mem_rwb,
// mem_addr[5:0], mem_wdata[7:0], mem_rdata[7:0]. Status: busy, owner.
interface dual_port_mem_arbiter_if;
  logic       req0;
  logic       rwb0;
  logic [5:0] addr0;
  logic [7:0] wdata0;
  logic       ack0;
  logic [7:0] rdata0;

  logic       req1;
  logic       rwb1;
  logic [5:0] addr1;
  logic [7:0] wdata1;
  logic       ack1;
  logic [7:0] rdata1;

  logic       mem_cs;
  logic       mem_rwb;
  logic [5:0] mem_addr;
  logic [7:0] mem_wdata;
  logic [7:0] mem_rdata;

  logic       busy;
  logic       owner;

  modport slave (
    input  req0, rwb0, addr0, wdata0,
    input  req1, rwb1, addr1, wdata1,
    input  mem_rdata,
    output ack0, rdata0, ack1, rdata1,
    output mem_cs, mem_rwb, mem_addr, mem_wdata,
    output busy, owner
  );

  modport master (
    output req0, rwb0, addr0, wdata0,
    output req1, rwb1, addr1, wdata1,
    output mem_rdata,
    input  ack0, rdata0, ack1, rdata1,
    input  mem_cs, mem_rwb, mem_addr, mem_wdata,
    input  busy, owner
  );
endinterface

// File: rtl/dual_port_mem_arbiter.sv
// Round-robin arbiter sharing one 64x8 memory between two requesters.
// A granted access holds mem_cs for LATENCY cycles, captures read data in
// the final mem_cs cycle, then pulses the owner's ack for one cycle.
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous, active-high reset
//   bus   : dual_port_mem_arbiter_if.slave (requests, memory bus, status)
// Parameters:
//   LATENCY : cycles mem_cs is held per access (1..15)
//   CNT_W   : latency counter width, 2**CNT_W > LATENCY
module dual_port_mem_arbiter #(
  parameter int LATENCY = 2,
  parameter int CNT_W   = 4
) (
  input logic                    clk,
  input logic                    reset,
  dual_port_mem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ACCESS, ACK} state_t;

  state_t           state_q, state_d;
  logic             prio_q, prio_d;
  logic             owner_q, owner_d;
  logic             busy_q, busy_d;
  logic             cs_q, cs_d;
  logic             ack0_q, ack0_d;
  logic             ack1_q, ack1_d;
  logic             rwb_q, rwb_d;
  logic [5:0]       addr_q, addr_d;
  logic [7:0]       wdata_q, wdata_d;
  logic [7:0]       rdata0_q, rdata0_d;
  logic [7:0]       rdata1_q, rdata1_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             win;

  // All outputs come straight from registers; the combinational block only
  // computes their next values, so no input reaches an output directly.
  always_comb begin
    state_d  = state_q;
    prio_d   = prio_q;
    owner_d  = owner_q;
    busy_d   = busy_q;
    cs_d     = cs_q;
    ack0_d   = ack0_q;
    ack1_d   = ack1_q;
    rwb_d    = rwb_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    cnt_d    = cnt_q;
    // A lone requester wins outright; under contention prio decides.
    win      = (bus.req0 & bus.req1) ? prio_q : bus.req1;

    unique case (state_q)
      IDLE: begin
        if (bus.req0 | bus.req1) begin
          rwb_d   = win ? bus.rwb1   : bus.rwb0;
          addr_d  = win ? bus.addr1  : bus.addr0;
          wdata_d = win ? bus.wdata1 : bus.wdata0;
          owner_d = win;
          cs_d    = 1'b1;
          busy_d  = 1'b1;
          cnt_d   = CNT_W'(LATENCY - 1);
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          if (rwb_q) begin
            if (owner_q) rdata1_d = bus.mem_rdata;
            else         rdata0_d = bus.mem_rdata;
          end
          cs_d = 1'b0;
          if (owner_q) ack1_d = 1'b1;
          else         ack0_d = 1'b1;
          state_d = ACK;
        end
      end
      ACK: begin
        ack0_d  = 1'b0;
        ack1_d  = 1'b0;
        busy_d  = 1'b0;
        prio_d  = ~owner_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prio_q   <= 1'b0;
      owner_q  <= 1'b0;
      busy_q   <= 1'b0;
      cs_q     <= 1'b0;
      ack0_q   <= 1'b0;
      ack1_q   <= 1'b0;
      rwb_q    <= 1'b1;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
      cnt_q    <= '0;
    end else begin
      prio_q   <= prio_d;
      owner_q  <= owner_d;
      busy_q   <= busy_d;
      cs_q     <= cs_d;
      ack0_q   <= ack0_d;
      ack1_q   <= ack1_d;
      rwb_q    <= rwb_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
      cnt_q    <= cnt_d;
    end
  end

  assign bus.ack0      = ack0_q;
  assign bus.ack1      = ack1_q;
  assign bus.rdata0    = rdata0_q;
  assign bus.rdata1    = rdata1_q;
  assign bus.mem_cs    = cs_q;
  assign bus.mem_rwb   = rwb_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.busy      = busy_q;
  assign bus.owner     = owner_q;

endmodule

// File: tb/tb_dual_port_mem_arbiter.sv
module tb_dual_port_mem_arbiter;
  logic clk = 1'b0;
  logic reset;
  int   n_chk  = 0;
  int   n_fail = 0;

  dual_port_mem_arbiter_if b2 ();
  dual_port_mem_arbiter_if b1 ();

  dual_port_mem_arbiter #(.LATENCY(2), .CNT_W(4)) dut2 (
    .clk(clk), .reset(reset), .bus(b2.slave));
  dual_port_mem_arbiter #(.LATENCY(1), .CNT_W(4)) dut1 (
    .clk(clk), .reset(reset), .bus(b1.slave));

  always #5 clk = ~clk;

  // Fixed memory contents
  function automatic logic [7:0] mem_f(input logic [5:0] a);
    case (a)
      6'h2A:   mem_f = 8'h5C;
      6'h05:   mem_f = 8'h11;
      6'h06:   mem_f = 8'h22;
      6'h10:   mem_f = 8'h33;
      6'h20:   mem_f = 8'h44;
      6'h07:   mem_f = 8'h66;
      default: mem_f = 8'hEE;
    endcase
  endfunction

  assign b2.mem_rdata = mem_f(b2.mem_addr);
  assign b1.mem_rdata = mem_f(b1.mem_addr);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1;
    b2.req0 = 0; b2.rwb0 = 1; b2.addr0 = '0; b2.wdata0 = '0;
    b2.req1 = 0; b2.rwb1 = 1; b2.addr1 = '0; b2.wdata1 = '0;
    b1.req0 = 0; b1.rwb0 = 1; b1.addr0 = '0; b1.wdata0 = '0;
    b1.req1 = 0; b1.rwb1 = 1; b1.addr1 = '0; b1.wdata1 = '0;
    tick(); tick();

    // Reset values
    chk("rst_busy",   8'(b2.busy),   8'h0);
    chk("rst_cs",     8'(b2.mem_cs), 8'h0);
    chk("rst_ack0",   8'(b2.ack0),   8'h0);
    chk("rst_ack1",   8'(b2.ack1),   8'h0);
    chk("rst_rwb",    8'(b2.mem_rwb), 8'h1);
    chk("rst_addr",   8'(b2.mem_addr), 8'h00);
    chk("rst_wdata",  b2.mem_wdata,  8'h00);
    chk("rst_rdata0", b2.rdata0,     8'h00);
    chk("rst_rdata1", b2.rdata1,     8'h00);
    chk("rst_owner",  8'(b2.owner),  8'h0);
    reset = 1'b0;
    tick();

    // Single read by requester 0
    b2.req0 = 1; b2.rwb0 = 1; b2.addr0 = 6'h2A;
    tick();
    chk("rd_cs1",    8'(b2.mem_cs),   8'h1);
    chk("rd_addr1",  8'(b2.mem_addr), 8'h2A);
    chk("rd_rwb",    8'(b2.mem_rwb),  8'h1);
    chk("rd_busy",   8'(b2.busy),     8'h1);
    chk("rd_owner",  8'(b2.owner),    8'h0);
    chk("rd_noack1", 8'(b2.ack0),     8'h0);
    tick();
    chk("rd_cs2",    8'(b2.mem_cs),   8'h1);
    chk("rd_noack2", 8'(b2.ack0),     8'h0);
    tick();
    chk("rd_cs_off", 8'(b2.mem_cs),   8'h0);
    chk("rd_ack",    8'(b2.ack0),     8'h1);
    chk("rd_rdata0", b2.rdata0,       8'h5C);
    chk("rd_rdata1", b2.rdata1,       8'h00);
    b2.req0 = 0;
    tick();
    chk("rd_ackoff", 8'(b2.ack0),     8'h0);
    chk("rd_idle",   8'(b2.busy),     8'h0);
    chk("rd_hold",   8'(b2.mem_addr), 8'h2A);

    // Write by requester 1
    b2.req1 = 1; b2.rwb1 = 0; b2.addr1 = 6'h3F; b2.wdata1 = 8'hA7;
    tick();
    chk("wr_cs1",    8'(b2.mem_cs),   8'h1);
    chk("wr_rwb",    8'(b2.mem_rwb),  8'h0);
    chk("wr_addr",   8'(b2.mem_addr), 8'h3F);
    chk("wr_wdata",  b2.mem_wdata,    8'hA7);
    chk("wr_owner",  8'(b2.owner),    8'h1);
    tick();
    chk("wr_cs2",    8'(b2.mem_cs),   8'h1);
    chk("wr_wdata2", b2.mem_wdata,    8'hA7);
    tick();
    chk("wr_ack1",   8'(b2.ack1),     8'h1);
    chk("wr_ack0",   8'(b2.ack0),     8'h0);
    chk("wr_rdata1", b2.rdata1,       8'h00);
    chk("wr_rdata0", b2.rdata0,       8'h5C);
    b2.req1 = 0;
    tick();
    chk("wr_ackoff", 8'(b2.ack1),     8'h0);

    // Contention after reset: grants alternate 0,1,0,1
    reset = 1'b1;
    tick();
    reset = 1'b0;
    b2.req0 = 1; b2.rwb0 = 1; b2.addr0 = 6'h05;
    b2.req1 = 1; b2.rwb1 = 1; b2.addr1 = 6'h06;
    for (int i = 0; i < 4; i++) begin
      logic exp_own;
      exp_own = logic'(i % 2);
      tick();
      chk($sformatf("ct_owner%0d", i), 8'(b2.owner),  8'(exp_own));
      chk($sformatf("ct_cs%0d", i),    8'(b2.mem_cs), 8'h1);
      chk($sformatf("ct_addr%0d", i),  8'(b2.mem_addr), exp_own ? 8'h06 : 8'h05);
      tick();
      tick();
      chk($sformatf("ct_ack0_%0d", i), 8'(b2.ack0), exp_own ? 8'h0 : 8'h1);
      chk($sformatf("ct_ack1_%0d", i), 8'(b2.ack1), exp_own ? 8'h1 : 8'h0);
      tick();
      chk($sformatf("ct_noack%0d", i), 8'({b2.ack1, b2.ack0}), 8'h0);
    end
    chk("ct_rdata0", b2.rdata0, 8'h11);
    chk("ct_rdata1", b2.rdata1, 8'h22);
    b2.req0 = 0; b2.req1 = 0;

    // Mid-transaction change of address and req drop
    b2.req0 = 1; b2.rwb0 = 1; b2.addr0 = 6'h10;
    tick();
    chk("mid_addr1", 8'(b2.mem_addr), 8'h10);
    b2.addr0 = 6'h20; b2.req0 = 0;
    tick();
    chk("mid_addr2", 8'(b2.mem_addr), 8'h10);
    chk("mid_cs",    8'(b2.mem_cs),   8'h1);
    tick();
    chk("mid_ack",   8'(b2.ack0),     8'h1);
    chk("mid_rdata", b2.rdata0,       8'h33);
    tick();
    chk("mid_ackoff", 8'(b2.ack0),    8'h0);
    tick();
    chk("mid_nogrant", 8'(b2.mem_cs), 8'h0);

    // Reset during 2nd ACCESS cycle; prio is 1 here, reset returns it to 0
    b2.req1 = 1; b2.rwb1 = 1; b2.addr1 = 6'h07;
    tick();
    chk("ra_owner", 8'(b2.owner), 8'h1);
    tick();
    chk("ra_cs2", 8'(b2.mem_cs), 8'h1);
    reset = 1'b1;
    #1;
    chk("ra_cs",     8'(b2.mem_cs),   8'h0);
    chk("ra_busy",   8'(b2.busy),     8'h0);
    chk("ra_ack1",   8'(b2.ack1),     8'h0);
    chk("ra_rwb",    8'(b2.mem_rwb),  8'h1);
    chk("ra_addr",   8'(b2.mem_addr), 8'h00);
    chk("ra_owner0", 8'(b2.owner),    8'h0);
    chk("ra_rdata0", b2.rdata0,       8'h00);
    chk("ra_rdata1", b2.rdata1,       8'h00);
    b2.req1 = 0;
    tick();
    chk("ra_noack", 8'({b2.ack1, b2.ack0}), 8'h0);
    reset = 1'b0;
    b2.req0 = 1; b2.rwb0 = 1; b2.addr0 = 6'h05;
    b2.req1 = 1; b2.rwb1 = 1; b2.addr1 = 6'h07;
    tick();
    chk("ra_regrant", 8'(b2.owner), 8'h0);
    chk("ra_regcs",   8'(b2.mem_cs), 8'h1);
    tick();
    tick();
    chk("ra_reack0", 8'(b2.ack0), 8'h1);
    b2.req0 = 0; b2.req1 = 0;
    tick();

    // LATENCY=1 build
    chk("l1_rst_cs", 8'(b1.mem_cs), 8'h0);
    b1.req0 = 1; b1.rwb0 = 1; b1.addr0 = 6'h2A;
    tick();
    chk("l1_cs",    8'(b1.mem_cs), 8'h1);
    chk("l1_noack", 8'(b1.ack0),   8'h0);
    tick();
    chk("l1_csoff", 8'(b1.mem_cs), 8'h0);
    chk("l1_ack",   8'(b1.ack0),   8'h1);
    chk("l1_rdata", b1.rdata0,     8'h5C);
    b1.req0 = 0;
    tick();
    chk("l1_ackoff", 8'(b1.ack0),  8'h0);
    chk("l1_busy",   8'(b1.busy),  8'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
